// File: rtl/spi_wrapper.sv
// spi_wrapper: SPI slave front-end plus single-port RAM, all in the clk domain.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous reset, active HIGH (name kept for port compatibility)
//   MOSI   serial command/data from master, sampled on rising clk
//   SS_n   active-low frame select; high at any edge aborts the frame
//   MISO   serial read data back to master, MSB first
//
// Frame: 10-bit word MSB first. Bits [9:8] select
//   00 write address, 01 write data, 10 read address, 11 read data.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for SS_n low, MOSI ignored
// CHK_CMD   | first frame bit sampled, picks the frame type
// WRITE     | shifting a write-address or write-data frame
// READ_ADD  | shifting a read-address frame, sets rd_flag on completion
// READ_DATA | shifting a read-data frame, clears rd_flag on completion

module spi_wrapper #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8     // must not exceed the 8-bit data field
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t         state;
  state_t         next_state;

  // slave <-> RAM link
  logic [9:0]     rx_data;
  logic           rx_valid;
  logic [7:0]     tx_data;
  logic           tx_valid;

  // receiver
  logic [3:0]     bit_cnt;        // frame bits still to shift, down-counter
  logic           rd_flag;        // read address received, next 1-frame is read data

  // transmitter
  logic [7:0]     tx_shift;
  logic [2:0]     tx_cnt;         // bits still to send after the MSB

  // RAM
  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  // ------------------------------------------------------------------
  // Slave FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (SS_n) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)        next_state = WRITE;
          else if (rd_flag) next_state = READ_DATA;
          else              next_state = READ_ADD;
        end
        default: next_state = state;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Receive shifter. Once bit_cnt reaches zero the frame is complete and
  // further MOSI bits are ignored until SS_n returns high.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bit_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rd_flag  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        bit_cnt <= '0;
      end else begin
        case (state)
          CHK_CMD: begin
            rx_data <= {rx_data[8:0], MOSI};
            bit_cnt <= 4'd9;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt != 4'd0) begin
              rx_data <= {rx_data[8:0], MOSI};
              bit_cnt <= bit_cnt - 4'd1;
              if (bit_cnt == 4'd1) begin
                rx_valid <= 1'b1;
                if (state == READ_ADD)       rd_flag <= 1'b1;
                else if (state == READ_DATA) rd_flag <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------
  // Transmit shifter: MSB goes out the cycle after tx_valid, then seven
  // more bits, then MISO rests at 0.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_shift <= '0;
      tx_cnt   <= '0;
      MISO     <= 1'b0;
    end else if (SS_n) begin
      tx_cnt <= '0;
      MISO   <= 1'b0;
    end else if (tx_valid) begin
      tx_shift <= tx_data;
      tx_cnt   <= 3'd7;
      MISO     <= tx_data[7];
    end else if (tx_cnt != 3'd0) begin
      MISO     <= tx_shift[6];
      tx_shift <= {tx_shift[6:0], 1'b0};
      tx_cnt   <= tx_cnt - 3'd1;
    end else begin
      MISO <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // RAM side: acts one cycle after rx_valid. Contents are not reset.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (rx_data[9:8])
          2'b00: wr_addr <= rx_data[ADDR_SIZE-1:0];
          2'b10: rd_addr <= rx_data[ADDR_SIZE-1:0];
          2'b11: begin
            tx_data  <= mem[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && rx_valid && (rx_data[9:8] == 2'b01))
      mem[wr_addr] <= rx_data[7:0];
  end

endmodule

// File: tb/tb_spi_wrapper.sv
// tb_spi_wrapper: directed plus randomized frames against a transaction-level
// model of the SPI/RAM behaviour. Each frame's MISO trace is captured one
// sample per clock (on the falling edge) and compared with the trace the
// model predicts.

module tb_spi_wrapper;

  logic clk = 1'b0;
  logic rst_n;
  logic MOSI;
  logic SS_n;
  logic MISO;

  always #5 clk = ~clk;

  spi_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .MOSI  (MOSI),
    .SS_n  (SS_n),
    .MISO  (MISO)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] m_mem [256];
  bit         m_written [256];
  logic [7:0] m_wr_addr;
  logic [7:0] m_rd_addr;
  bit         m_flag;
  logic [7:0] written_q [$];

  function automatic void model_reset();
    m_wr_addr = 8'h00;
    m_rd_addr = 8'h00;
    m_flag    = 1'b0;
  endfunction

  // Applies one complete 10-bit frame to the model and returns the MISO
  // trace expected: sample k is MISO after the k-th clock of the frame,
  // clock 0 being the IDLE cycle. Data bits appear at samples 13..20.
  function automatic logic [31:0] model_frame(input logic [9:0] word);
    logic [31:0] exp_trace;
    logic [7:0]  b;
    exp_trace = '0;
    if (word[9]) m_flag = !m_flag;
    case (word[9:8])
      2'b00: m_wr_addr = word[7:0];
      2'b01: begin
        m_mem[m_wr_addr] = word[7:0];
        if (!m_written[m_wr_addr]) written_q.push_back(m_wr_addr);
        m_written[m_wr_addr] = 1'b1;
      end
      2'b10: m_rd_addr = word[7:0];
      default: begin
        b = m_mem[m_rd_addr];
        for (int i = 0; i < 8; i++) exp_trace[13 + i] = b[7 - i];
      end
    endcase
    return exp_trace;
  endfunction

  function automatic logic rand_bit();
    return ($urandom & 1) != 0;
  endfunction

  // Drives SS_n low for 1 + nbits + hold clocks, shifting nbits of word
  // (MSB first) and random bits afterwards, then raises SS_n.
  task automatic run_frame(input logic [9:0] word, input int nbits, input int hold,
                           output logic [31:0] got);
    int last;
    got  = '0;
    last = 1 + nbits + hold;
    for (int k = 0; k < last; k++) begin
      @(negedge clk);
      if (k > 0) got[k] = MISO;
      if (k == 0) begin
        SS_n = 1'b0;
        MOSI = rand_bit();
      end else if (k <= nbits) begin
        MOSI = word[10 - k];
      end else begin
        MOSI = rand_bit();
      end
    end
    @(negedge clk);
    got[last] = MISO;
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    got[last + 1] = MISO;
    @(negedge clk);
  endtask

  task automatic do_frame(input logic [9:0] word, input int nbits, input int hold,
                          input string tag, output logic [31:0] got);
    logic [31:0] exp_trace;
    run_frame(word, nbits, hold, got);
    exp_trace = (nbits == 10) ? model_frame(word) : 32'h0;
    checks++;
    assert (got === exp_trace)
      else begin
        errors++;
        $error("FAIL %s word=%h miso_trace got=%h exp=%h", tag, word, got, exp_trace);
      end
  endtask

  function automatic logic [7:0] trace_byte(input logic [31:0] t);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7 - i] = t[13 + i];
    return b;
  endfunction

  task automatic check_byte(input logic [31:0] t, input logic [7:0] exp_b, input string tag);
    logic [7:0] b;
    b = trace_byte(t);
    checks++;
    assert (b === exp_b)
      else begin
        errors++;
        $error("FAIL %s read byte got=%h exp=%h", tag, b, exp_b);
      end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    assert (MISO === 1'b0)
      else begin
        errors++;
        $error("FAIL %s miso in reset got=%b exp=0", tag, MISO);
      end
    rst_n = 1'b0;
    SS_n  = 1'b1;
    model_reset();
  endtask

  logic [31:0] got;
  logic [9:0]  w;
  int          op;

  initial begin
    rst_n = 1'b1;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    for (int i = 0; i < 256; i++) m_written[i] = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    checks++;
    assert (MISO === 1'b0)
      else begin
        errors++;
        $error("FAIL reset_miso got=%b exp=0", MISO);
      end
    rst_n = 1'b0;
    @(negedge clk);

    // directed sequence
    do_frame(10'h0FC, 10, 0,  "wr_addr",   got);
    do_frame(10'h1B1, 10, 0,  "wr_data",   got);
    do_frame(10'h2FC, 10, 0,  "rd_addr",   got);
    do_frame(10'h3BC, 10, 14, "rd_data",   got);
    check_byte(got, 8'hB1, "rd_data_b1");
    do_frame(10'h1AA, 5,  0,  "abort",     got);
    do_frame(10'h2FC, 10, 2,  "rd_addr2",  got);
    do_frame(10'h3BC, 10, 14, "rd_after_abort", got);
    check_byte(got, 8'hB1, "abort_kept_b1");

    // reset clears addresses and flag, keeps RAM
    pulse_reset("reset_idle");
    do_frame(10'h15A, 10, 0, "wr_mem0", got);
    do_frame(10'h2FC, 10, 0, "rd_addr_fc", got);

    // reset in the middle of a write-data frame
    @(negedge clk);
    SS_n = 1'b0;
    w = 10'h1FF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      MOSI = w[10 - k];
    end
    pulse_reset("reset_midframe");
    @(negedge clk);
    do_frame(10'h300, 10, 14, "rd_after_reset", got);
    check_byte(got, 8'h5A, "rd_mem0_5a");

    // randomized traffic
    for (int n = 0; n < 160; n++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: do_frame({2'b00, 8'($urandom_range(0, 255))}, 10, int'($urandom_range(0, 3)), "rnd_wr_addr", got);
        1: do_frame({2'b01, 8'($urandom_range(0, 255))}, 10, int'($urandom_range(0, 3)), "rnd_wr_data", got);
        2: begin
          if (written_q.size() > 0 && rand_bit())
            w = {2'b10, written_q[$urandom_range(0, written_q.size() - 1)]};
          else
            w = {2'b10, 8'($urandom_range(0, 255))};
          do_frame(w, 10, int'($urandom_range(0, 3)), "rnd_rd_addr", got);
        end
        3: begin
          if (m_written[m_rd_addr])
            do_frame({2'b11, 8'($urandom_range(0, 255))}, 10, 14, "rnd_rd_data", got);
          else
            do_frame({2'b01, 8'($urandom_range(0, 255))}, 10, 1, "rnd_wr_data", got);
        end
        default: do_frame(10'($urandom_range(0, 1023)), int'($urandom_range(0, 9)), 0, "rnd_abort", got);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_wrapper.md
Name: spi_wrapper

Overview:
SPI slave front-end plus an on-chip single-port RAM (default 256x8), clocked in the system clock domain (no separate SCK). The master frames each transaction with SS_n low and sends a 10-bit command word MSB first on MOSI. Bits [9:8] select write-address, write-data, read-address or read-data. Read data is returned serially on MISO.

Parameters:
MEM_DEPTH, 256, number of RAM words
ADDR_SIZE, 8, address width (log2 MEM_DEPTH); word width fixed at 8

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; synchronous, active-high (asserted = 1) despite the suffix; name retained for port compatibility
MOSI  input  1  serial data from master, sampled on rising clk
SS_n  input  1  active-low slave select/frame
MISO  output  1  serial read data to master

Behaviour:
- Reset (rst_n=1 at posedge): FSM->IDLE, MISO=0, shift/bit counters=0, rx_valid=0, tx_valid=0, wr_addr=rd_addr=0, read-address-received flag=0. RAM contents not reset.
- Internal split: SPI slave (FSM + shifters) and RAM, linked by rx_data[9:0]/rx_valid and tx_data[7:0]/tx_valid.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 at posedge -> CHK_CMD. MOSI ignored this cycle.
- CHK_CMD: sampled MOSI is frame bit 9 and is shifted in. MOSI=0 -> WRITE. MOSI=1 and flag=0 -> READ_ADD. MOSI=1 and flag=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift in the remaining 9 bits, one per clock, MSB first. After the 10th bit, rx_data holds the word and rx_valid pulses high for exactly 1 cycle.
- End of READ_ADD frame sets flag=1. End of READ_DATA frame clears flag=0.
- RAM action on rx_valid, by rx_data[9:8]:
  - 00: wr_addr<=rx_data[7:0]
  - 01: mem[wr_addr]<=rx_data[7:0]
  - 10: rd_addr<=rx_data[7:0]
  - 11: tx_data<=mem[rd_addr] and tx_valid pulses 1 cycle; rx_data[7:0] is a don't-care.
- Latency: RAM acts 1 cycle after rx_valid.
- Read-data return:
  - Cycle after tx_valid: slave loads tx_data and drives MISO=tx_data[7].
  - Following 7 cycles: tx_data[6]..[0], one bit per cycle. Then MISO returns to 0.
  - Full return completes within 12 clocks of the last MOSI bit. Master keeps SS_n low.
- SS_n=1 at any posedge: FSM->IDLE immediately, partial frame discarded, no rx_valid, bit counter cleared, MISO=0. Flag and addresses unchanged.
- Frames while in IDLE or after the 10th bit and before SS_n rises: extra MOSI bits ignored.
- rd_addr and wr_addr are independent registers.
- rst_n wins over all other inputs, including mid-frame.

Test Plan:
- Reset: rst_n=1 for 1 clk -> MISO=0, FSM IDLE, then release.
- Write address: SS_n=0, 1 clk, then shift 10'h0FC MSB first, SS_n=1 -> wr_addr=0xFC, no MISO activity.
- Write data: frame 10'h1B1 -> mem[0xFC]=0xB1.
- Read address: frame 10'h2FC (MOSI=1 at CHK_CMD) -> rd_addr=0xFC, flag=1.
- Read data: frame 10'h3BC, hold SS_n low 14 clks -> MISO serially outputs 1,0,1,1,0,0,0,1 (0xB1, MSB first); flag=0 afterwards.
- Abort: raise SS_n after 5 bits of 10'h1AA -> mem[0xFC] still 0xB1; next frame decodes normally.
